// File: rtl/sq_commit_buffer_pkg.sv
// sq_commit_buffer_pkg
//   Shared definitions for the post-retirement store commit buffer:
//   buffer geometry, the SQ entry packet carried from the store queue,
//   and a small retire-mask popcount helper.
package sq_commit_buffer_pkg;

  localparam int SCB_DEPTH        = 8;
  localparam int SCB_ADDR_WIDTH   = 3;
  localparam int SCB_RETIRE_WIDTH = 3;

  // Store queue entry as delivered at retirement; data is already lane-aligned.
  typedef struct packed {
    logic        ready;
    logic [3:0]  usebytes;
    logic [31:0] addr;
    logic [31:0] data;
  } SQ_ENTRY_PACKET;

  // Number of stores retired by a 3-bit retire mask.
  function automatic logic [1:0] popcount3(input logic [2:0] mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]} + {1'b0, mask[2]};
  endfunction

endpackage

// File: rtl/sq_commit_buffer_chk.sv
// sq_commit_buffer_chk
//   Interface checker for sq_commit_buffer: the retire mask must be
//   contiguous from the oldest slot and must never exceed retire_space.
// Ports: clk, rst (active-low), retire_mask, retire_space.
module sq_commit_buffer_chk
  import sq_commit_buffer_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic [2:0] retire_mask,
  input logic [1:0] retire_space
);

  // Sample the retire interface at each active edge outside reset.
  always @(posedge clk) begin
    if (rst) begin
      assert (retire_mask inside {3'b000, 3'b001, 3'b011, 3'b111});
      assert (popcount3(retire_mask) <= retire_space);
    end
  end

endmodule

// File: rtl/sq_commit_buffer_fwd_merge.sv
// sq_commit_buffer_fwd_merge
//   Combinational store-to-load forwarding over the commit buffer.
//   For each byte lane, the youngest buffered entry whose word address
//   matches the probe and that writes that lane supplies the byte.
// Ports:
//   entries    - whole entry array (registered state of the top)
//   head/count - occupancy window; only head..head+count-1 are live
//   probe_addr - load address, bits [31:2] compared
//   hit/data   - per-lane hit mask and merged data (missed lanes are 0)
module sq_commit_buffer_fwd_merge
  import sq_commit_buffer_pkg::*;
#(
  parameter int DEPTH = SCB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  SQ_ENTRY_PACKET [DEPTH-1:0] entries,
  input  logic [AW-1:0]              head,
  input  logic [AW:0]                count,
  input  logic [31:0]                probe_addr,
  output logic [3:0]                 hit,
  output logic [31:0]                data
);

  logic [AW-1:0] idx_s;
  logic          match_s;
  logic          unused_bits_s;

  // Walk oldest to youngest so a younger match overwrites an older one.
  always_comb begin
    hit     = 4'b0000;
    data    = 32'h0000_0000;
    idx_s   = '0;
    match_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s   = head + AW'(k);
      match_s = ((AW+1)'(k) < count) &&
                (entries[idx_s].addr[31:2] == probe_addr[31:2]);
      for (int lane = 0; lane < 4; lane++) begin
        if (match_s && entries[idx_s].usebytes[lane]) begin
          hit[lane]          = 1'b1;
          data[lane*8 +: 8]  = entries[idx_s].data[lane*8 +: 8];
        end else begin
          hit[lane]          = hit[lane];
        end
      end
    end
  end

  // Byte offsets and the ready flag play no part in word-level forwarding.
  always_comb begin
    unused_bits_s = ^probe_addr[1:0];
    for (int k = 0; k < DEPTH; k++) begin
      unused_bits_s = unused_bits_s ^ entries[k].ready ^ (^entries[k].addr[1:0]);
    end
  end

endmodule

// File: rtl/sq_commit_buffer.sv
// sq_commit_buffer
//   In-order circular buffer between store-queue retirement and the data
//   memory port. Accepts up to three retired stores per cycle, drains one
//   per cycle over a valid/ready handshake and forwards buffered bytes to
//   younger loads.
// Ports:
//   clk, rst                   - clock, asynchronous active-low reset
//   retire_mask/retire_entries - stores committing this cycle ([0] oldest)
//   retire_space               - free slots, capped at 3, from registered count
//   mem_req_*                  - head entry presented to memory
//   mem_req_ready              - memory accepts the head this cycle
//   ld_probe_addr/hit/data     - forwarding probe
//   empty                      - buffer holds no stores
module sq_commit_buffer
  import sq_commit_buffer_pkg::*;
#(
  parameter int DEPTH        = SCB_DEPTH,
  parameter int RETIRE_WIDTH = SCB_RETIRE_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [RETIRE_WIDTH-1:0]           retire_mask,
  input  SQ_ENTRY_PACKET [RETIRE_WIDTH-1:0] retire_entries,
  output logic [1:0]                        retire_space,
  output logic                              mem_req_valid,
  output logic [31:0]                       mem_req_addr,
  output logic [31:0]                       mem_req_data,
  output logic [3:0]                        mem_req_be,
  input  logic                              mem_req_ready,
  input  logic [31:0]                       ld_probe_addr,
  output logic [3:0]                        ld_probe_hit,
  output logic [31:0]                       ld_probe_data,
  output logic                              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  SQ_ENTRY_PACKET [DEPTH-1:0] entries_r;
  logic [AW-1:0]              head_r;
  logic [AW-1:0]              tail_r;
  logic [CW-1:0]              count_r;
  logic [1:0]                 space_r;

  logic [1:0]                 push_cnt_s;
  logic                       pop_s;
  logic [CW-1:0]              count_next_s;
  logic [CW-1:0]              free_next_s;
  logic [1:0]                 space_next_s;
  SQ_ENTRY_PACKET             head_entry_s;

  // Push count, pop decision, next occupancy and the space it leaves.
  always_comb begin
    push_cnt_s = 2'd0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      push_cnt_s = push_cnt_s + {1'b0, retire_mask[i]};
    end
    pop_s        = (count_r != CW'(0)) && mem_req_ready;
    count_next_s = count_r + CW'(push_cnt_s) - CW'(pop_s);
    free_next_s  = CW'(DEPTH) - count_next_s;
    if (free_next_s >= CW'(3)) begin
      space_next_s = 2'd3;
    end else begin
      space_next_s = free_next_s[1:0];
    end
  end

  // Entry array, pointers, occupancy and registered free-space count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_r <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      space_r   <= 2'd3;
    end else begin
      // Retire mask is contiguous from bit 0, so slot i lands at tail+i.
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (retire_mask[i]) begin
          entries_r[tail_r + AW'(i)] <= retire_entries[i];
        end
      end
      tail_r  <= tail_r + AW'(push_cnt_s);
      head_r  <= head_r + AW'(pop_s);
      count_r <= count_next_s;
      space_r <= space_next_s;
    end
  end

  assign head_entry_s = entries_r[head_r];
  assign mem_req_valid = (count_r != CW'(0));
  assign empty         = (count_r == CW'(0));
  assign retire_space  = space_r;

  // Payload is forced to zero whenever no request is outstanding.
  assign mem_req_addr = mem_req_valid ? {head_entry_s.addr[31:2], 2'b00} : 32'h0000_0000;
  assign mem_req_data = mem_req_valid ? head_entry_s.data : 32'h0000_0000;
  assign mem_req_be   = mem_req_valid ? head_entry_s.usebytes : 4'b0000;

  sq_commit_buffer_fwd_merge #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd_merge (
    .entries    (entries_r),
    .head       (head_r),
    .count      (count_r),
    .probe_addr (ld_probe_addr),
    .hit        (ld_probe_hit),
    .data       (ld_probe_data)
  );

endmodule

// File: doc/sq_commit_buffer.md
# sq_commit_buffer

Post-retirement store buffer directly downstream of the store queue (SQ). Accepts up to three retired SQ head entries per cycle, holds them in an in-order circular buffer, and drains them one per cycle to the data-memory port through a valid/ready handshake. Provides a byte-granular forwarding probe so loads see committed-but-undrained stores. Gives the retire stage a free-slot count so retirement never overflows the buffer.

## Interface
- DEPTH, 8, buffer entries; power of two, ≥ 4
- RETIRE_WIDTH, 3, max stores accepted per cycle; matches SQ retire width
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- retire_mask  in  3  bit i set: retire_entries[i] commits this cycle; legal values 000/001/011/111
- retire_entries  in  SQ_ENTRY_PACKET[2:0]  SQ head entries, [0] oldest; fields ready, usebytes[3:0], addr[31:0], data[31:0]
- retire_space  out  2  free slots, min(DEPTH−count, 3); retire stage must keep popcount(retire_mask) ≤ retire_space
- mem_req_valid  out  1  buffer head valid
- mem_req_addr  out  32  {head.addr[31:2], 2'b00}
- mem_req_data  out  32  head.data, lane-aligned as delivered by SQ, unshifted
- mem_req_be  out  4  head.usebytes
- mem_req_ready  in  1  memory accepts head this cycle
- ld_probe_addr  in  32  load word address, only bits [31:2] compared
- ld_probe_hit  out  4  byte lanes supplied by buffered stores
- ld_probe_data  out  32  merged bytes; lanes with hit=0 are 0
- empty  out  1  count == 0

## Operation
- State: entries[DEPTH], head/tail pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits.
- Push: for each set bit i in retire_mask, write retire_entries[i] at tail+i (mod DEPTH); tail += popcount; entry order preserved.
- Pop: mem_req_valid && mem_req_ready at edge → head += 1.
- count_next = count + pushes − pop; push and pop in the same cycle are both honoured.
- retire_space derives only from registered count (no credit for a same-cycle pop); combinational from state, not from retire_mask.
- Handshake: payload stable while mem_req_valid=1 and mem_req_ready=0; valid never drops without a pop.
- Forwarding: for each byte lane, youngest valid entry with addr[31:2] == ld_probe_addr[31:2] and usebytes[lane]=1 supplies the byte. Purely combinational from current state; entry popping this cycle still participates; entries pushed this cycle invisible until next cycle (SQ still holds them this cycle).
- Illegal retire_mask (non-contiguous) or push beyond space: simulation assertion fires; state behaviour undefined.
- Pointer wrap: modulo DEPTH, natural overflow of pointer bits.

## Timing
- Reset (rst=0, async): head=tail=count=0, all entries cleared; mem_req_valid=0, mem_req_addr/data/be=0, empty=1, retire_space=3, ld_probe_hit=0, ld_probe_data=0. Reset mid-drain discards all buffered stores; no request issued until a new push.
- Push-to-request latency: 1 cycle (store retired at edge N appears on mem_req_* during cycle N+1 when buffer was empty).
- Throughput: 1 drain per cycle with mem_req_ready held high.
- Full (count=DEPTH): retire_space=0, mem_req_valid=1. At count=DEPTH−1: retire_space=1.
- Empty: mem_req_valid=0; mem_req_ready ignored.

## Structure
- sys_defs.svh: reuse SQ_ENTRY_PACKET; add `SYS_SCB_DEPTH (8) and `SYS_SCB_ADDR_WIDTH (3).
- One sub-module: scb_fwd_merge, combinational per-lane youngest-match selection over the entry array given head and count.
- Top holds pointers, counters, push/pop logic and the handshake.

## Test plan
- Reset then retire_mask=011 {addr 0x1000, be 1111, data 0xDEADBEEF}, {0x1004, 1111, 0xCAFEBABE}, mem_req_ready=1 → cycle +1 request 0x1000/0xDEADBEEF, cycle +2 0x1004/0xCAFEBABE, cycle +3 empty=1.
- mem_req_ready=0; retire 3 stores on each of cycles 1 and 2, then 2 → count=8, retire_space=0, payload stable; raise ready → 8 drains in order, retire_space climbs 1,2,3.
- Push 0x2000 be=0011 data=0x0000_1122, then 0x2000 be=0110 data=0x0033_4400; probe 0x2002 → hit=0111, data=0x0033_4422; probe 0x3000 → hit=0000, data=0.
- count=7, ready=1, retire_mask=001 same cycle → count stays 7, order preserved, pointers wrap past 7 correctly over 20 cycles of streaming.
- 4 entries buffered, ready=0, assert rst low asynchronously mid-cycle → outputs at reset values immediately; after release, retire_space=3 and no stale request.
